// File: rtl/bsg_wormhole_router_adapter_tx_pkg.sv
// Shared types and sizing for the wormhole transmit adapter: header/packet layout
// (cord in the LSBs, then len, then payload) and flit-count helpers.
package bsg_wormhole_router_adapter_tx_pkg;

  localparam int max_payload_width_p = 64;
  localparam int len_width_p         = 4;
  localparam int cord_width_p        = 5;
  localparam int flit_width_p        = 32;

  localparam int pkt_w_lp     = cord_width_p + len_width_p + max_payload_width_p;
  localparam int max_flits_lp = (pkt_w_lp + flit_width_p - 1) / flit_width_p;
  localparam int cnt_w_lp     = (max_flits_lp > 1) ? $clog2(max_flits_lp) : 1;
  localparam int pad_w_lp     = max_flits_lp * flit_width_p;

  typedef struct packed {
    logic [len_width_p-1:0]  len;
    logic [cord_width_p-1:0] cord;
  } wh_hdr_s;

  typedef struct packed {
    logic [max_payload_width_p-1:0] payload;
    wh_hdr_s                        hdr;
  } wh_pkt_s;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  // A len that asks for more flits than the packet can ever need.
  function automatic logic len_ovf_f(input logic [len_width_p-1:0] len);
    return (len > len_width_p'(max_flits_lp - 1));
  endfunction

  // Index of the final flit: len, saturated at the widest possible packet.
  function automatic logic [cnt_w_lp-1:0] last_idx_f(input logic [len_width_p-1:0] len);
    logic [cnt_w_lp-1:0] idx;
    if (len_ovf_f(len)) begin
      idx = cnt_w_lp'(max_flits_lp - 1);
    end else begin
      idx = len[cnt_w_lp-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/bsg_wormhole_flit_shifter.sv
// Holds one zero-padded packet and steps through it a flit at a time; reports when
// the current flit is the last one the header's len asks for.
module bsg_wormhole_flit_shifter
  import bsg_wormhole_router_adapter_tx_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    load_i,
  input  logic                    adv_i,
  input  wh_pkt_s                 pkt_i,
  output logic [flit_width_p-1:0] flit_o,
  output logic                    last_o
);

  logic [max_flits_lp-1:0][flit_width_p-1:0] pad_q, pad_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic [cnt_w_lp-1:0] last_idx_q, last_idx_d;

  // Next-state for the packet store and the flit cursor.
  always_comb begin
    pad_d      = pad_q;
    last_idx_d = last_idx_q;
    count_d    = count_q;
    if (load_i) begin
      pad_d      = {{(pad_w_lp - pkt_w_lp){1'b0}}, pkt_i};
      last_idx_d = last_idx_f(pkt_i.hdr.len);
      count_d    = '0;
    end else if (adv_i) begin
      count_d = count_q + cnt_w_lp'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Packet data and last index carry no reset; they are only read after a load.
  always_ff @(posedge clk_i) begin
    pad_q      <= pad_d;
    last_idx_q <= last_idx_d;
  end

  // Flit cursor.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign flit_o = pad_q[count_q];
  assign last_o = (count_q == last_idx_q);

endmodule

// File: rtl/bsg_wormhole_router_adapter_tx.sv
// Wormhole transmit adapter: accepts whole packets and streams them as flits, with
// pass-through acceptance of the next packet on the last flit so links stay full.
module bsg_wormhole_router_adapter_tx
  import bsg_wormhole_router_adapter_tx_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [pkt_w_lp-1:0]     packet_i,
  input  logic                    packet_v_i,
  output logic                    packet_ready_and_o,
  output logic [flit_width_p-1:0] link_data_o,
  output logic                    link_v_o,
  input  logic                    link_ready_and_i,
  output logic                    len_err_o
);

  tx_state_e state_q, state_d;
  logic      err_q, err_d;
  logic      ready_s, done_s, adv_s, accept_s, last_s;
  wh_pkt_s   pkt_s;

  assign pkt_s = packet_i;

  // Handshake decode and next state; a packet taken on the last flit keeps us in SEND.
  always_comb begin
    ready_s = 1'b0;
    done_s  = 1'b0;
    adv_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_s = 1'b1;
      end
      ST_SEND: begin
        done_s  = link_ready_and_i & last_s;
        adv_s   = link_ready_and_i & ~last_s;
        ready_s = done_s;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase

    accept_s = reset_n_i & ready_s & packet_v_i;
    err_d    = err_q | (accept_s & len_ovf_f(pkt_s.hdr.len));

    if (accept_s) begin
      state_d = ST_SEND;
    end else if (done_s) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // State and sticky length-error flag.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  bsg_wormhole_flit_shifter u_shifter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (accept_s),
    .adv_i     (adv_s),
    .pkt_i     (pkt_s),
    .flit_o    (link_data_o),
    .last_o    (last_s)
  );

  assign packet_ready_and_o = ready_s & reset_n_i;
  assign link_v_o           = (state_q == ST_SEND);
  assign len_err_o          = err_q;

endmodule

// File: tb/tb_bsg_wormhole_router_adapter_tx.sv
// Self-checking bench: a queue of outstanding flits and a sticky error bit model the
// adapter; directed scenarios plus a randomized phase are checked every cycle.
module tb_bsg_wormhole_router_adapter_tx;
  import bsg_wormhole_router_adapter_tx_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset_n_i;
  logic [pkt_w_lp-1:0]     packet_i;
  logic                    packet_v_i;
  logic                    packet_ready_and_o;
  logic [flit_width_p-1:0] link_data_o;
  logic                    link_v_o;
  logic                    link_ready_and_i;
  logic                    len_err_o;

  always #5 clk = ~clk;

  bsg_wormhole_router_adapter_tx dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n_i),
    .packet_i           (packet_i),
    .packet_v_i         (packet_v_i),
    .packet_ready_and_o (packet_ready_and_o),
    .link_data_o        (link_data_o),
    .link_v_o           (link_v_o),
    .link_ready_and_i   (link_ready_and_i),
    .len_err_o          (len_err_o)
  );

  logic [31:0] exp_q[$];
  logic        rdy_q[$];
  bit          exp_err;
  bit          rnd_rdy;
  bit          accepted;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          xfers = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [pkt_w_lp-1:0] mk(input logic [4:0] cord, input logic [3:0] len,
                                             input logic [63:0] pl);
    return {pl, len, cord};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Packet of len L yields min(L,2)+1 flits cut from the zero-padded 96-bit image.
  task automatic model_push(input logic [pkt_w_lp-1:0] p);
    logic [95:0] padded;
    logic [3:0]  len;
    int          n;
    padded = 96'(p);
    len    = p[8:5];
    n      = (len > 4'd2) ? 3 : int'(len) + 1;
    for (int i = 0; i < n; i++) exp_q.push_back(padded[i*32 +: 32]);
    if (len > 4'd2) exp_err = 1'b1;
  endtask

  task automatic tick();
    bit ev, er;
    @(negedge clk);
    if (!reset_n_i) begin
      exp_q.delete();
      exp_err  = 1'b0;
      accepted = 1'b0;
    end else begin
      ev = (exp_q.size() != 0);
      er = (exp_q.size() == 0) || (exp_q.size() == 1 && link_ready_and_i);
      chk("link_v", link_v_o, ev);
      chk("pkt_ready", packet_ready_and_o, er);
      chk("len_err", len_err_o, exp_err);
      if (ev && link_v_o) chk("flit_data", link_data_o, exp_q[0]);
      accepted = packet_v_i && er;
      if (ev && link_ready_and_i) begin
        void'(exp_q.pop_front());
        xfers++;
      end
      if (accepted) model_push(packet_i);
    end
    @(posedge clk);
    #1;
    if (rdy_q.size() != 0) link_ready_and_i = rdy_q.pop_front();
    else if (rnd_rdy)      link_ready_and_i = 1'($urandom_range(0, 1));
    else                   link_ready_and_i = 1'b1;
  endtask

  task automatic send(input logic [pkt_w_lp-1:0] p, output int n);
    packet_i   = p;
    packet_v_i = 1'b1;
    accepted   = 1'b0;
    n          = 0;
    while (!accepted && n < 50) begin
      tick();
      n++;
    end
    chk("accept_seen", accepted, 1'b1);
    packet_v_i = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n, x0;
    reset_n_i        = 1'b0;
    packet_v_i       = 1'b0;
    packet_i         = '0;
    link_ready_and_i = 1'b1;
    rnd_rdy          = 1'b0;
    exp_err          = 1'b0;
    tick();
    tick();
    reset_n_i = 1'b1;
    tick();

    // 1: len=2 header layout and three consecutive flits
    x0 = xfers;
    send(mk(5'h03, 4'h2, 64'hDEAD_BEEF_0123_4567), n);
    chk("t1_hdr_v", link_v_o, 1'b1);
    chk("t1_hdr", link_data_o[8:0], 9'h043);
    drain(n);
    chk("t1_cycles", n, 3);
    chk("t1_xfers", xfers - x0, 3);

    // 2: len=0 header-only packet
    x0 = xfers;
    send(mk(5'h11, 4'h0, rnd64()), n);
    drain(n);
    chk("t2_cycles", n, 1);
    tick();
    chk("t2_xfers", xfers - x0, 1);

    // 3: back-to-back without a bubble
    x0 = xfers;
    send(mk(5'h07, 4'h2, rnd64()), n);
    send(mk(5'h1A, 4'h2, rnd64()), n);
    chk("t3_accept_gap", n, 3);
    drain(n);
    chk("t3_drain", n, 3);
    chk("t3_xfers", xfers - x0, 6);

    // 4: backpressure 1,0,0,1,0,1
    x0 = xfers;
    send(mk(5'h0C, 4'h2, rnd64()), n);
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    link_ready_and_i = rdy_q.pop_front();
    drain(n);
    chk("t4_cycles", n, 6);
    chk("t4_xfers", xfers - x0, 3);

    // randomized traffic with random backpressure and gaps
    rnd_rdy = 1'b1;
    for (int k = 0; k < 25; k++) begin
      send(mk(5'($urandom), 4'($urandom_range(0, 2)), rnd64()), n);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain(n);
    rnd_rdy = 1'b0;
    tick();

    // 5: overflow len, sticky error
    chk("t5_err_pre", len_err_o, 1'b0);
    x0 = xfers;
    send(mk(5'h15, 4'hF, rnd64()), n);
    drain(n);
    chk("t5_cycles", n, 3);
    chk("t5_xfers", xfers - x0, 3);
    chk("t5_err_set", len_err_o, 1'b1);
    send(mk(5'h02, 4'h1, rnd64()), n);
    drain(n);
    chk("t5_err_sticky", len_err_o, 1'b1);

    // 6: reset mid-packet, then a fresh packet from flit 0
    send(mk(5'h09, 4'h2, rnd64()), n);
    tick();
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    tick();
    chk("t6_v_after_reset", link_v_o, 1'b0);
    chk("t6_err_after_reset", len_err_o, 1'b0);
    x0 = xfers;
    send(mk(5'h1F, 4'h2, rnd64()), n);
    drain(n);
    chk("t6_cycles", n, 3);
    chk("t6_xfers", xfers - x0, 3);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
